// File: rtl/hamming_pkg.sv
// Shared types for the SECDED (22,16) scrubber:
// codeword width, error classes and scrubber FSM states.
package hamming_pkg;

  localparam int CW = 22;

  typedef enum logic [1:0] {
    CLEAN,
    SINGLE,
    PARITY,
    DOUBLE
  } err_class_t;

  typedef enum logic [2:0] {
    S_IDLE,
    S_ISSUE,
    S_CHECK,
    S_WRITE,
    S_DONE
  } scrub_state_t;

endpackage

// File: rtl/hamming_syndrome.sv
// Combinational SECDED checker.
// Ports: cw in; syn, op, cls, fixed (corrected codeword) out.
module hamming_syndrome
  import hamming_pkg::*;
(
  input  logic [CW-1:0] cw,
  output logic [4:0]    syn,
  output logic          op,
  output err_class_t    cls,
  output logic [CW-1:0] fixed
);

  always_comb begin
    syn = '0;
    for (int p = 1; p < CW; p++) begin
      for (int i = 0; i < 5; i++) begin
        if (((p >> i) & 1) == 1) syn[i] = syn[i] ^ cw[p];
      end
    end
  end

  assign op = ^cw;

  // Syndromes above 21 point outside the word, so they
  // can only come from multi-bit damage.
  always_comb begin
    cls   = CLEAN;
    fixed = cw;
    if (syn > 5'd21) begin
      cls = DOUBLE;
    end else if (syn != 5'd0 && op) begin
      cls        = SINGLE;
      fixed[syn] = ~cw[syn];
    end else if (syn == 5'd0 && op) begin
      cls      = PARITY;
      fixed[0] = ~cw[0];
    end else if (syn != 5'd0) begin
      cls = DOUBLE;
    end
  end

endmodule

// File: rtl/hamming_scrubber.sv
// Background ECC scrubber sharing one memory port with a host.
// Ports: start/busy/done control, host_req/host_gnt arbitration,
// mem_* port, corr/uncorr counters, err_addr and sticky err_flag.
module hamming_scrubber #(
  parameter int DEPTH = 64,
  parameter int AW    = 6,
  parameter int CW    = 22
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          start,
  output logic          busy,
  output logic          done,
  input  logic          host_req,
  output logic          host_gnt,
  output logic [AW-1:0] mem_addr,
  output logic          mem_re,
  input  logic [CW-1:0] mem_rdata,
  output logic          mem_we,
  output logic [CW-1:0] mem_wdata,
  output logic [15:0]   corr_count,
  output logic [15:0]   uncorr_count,
  output logic [AW-1:0] err_addr,
  output logic          err_flag
);
  import hamming_pkg::*;

  scrub_state_t state, state_n;
  logic [AW-1:0] addr;
  logic [4:0]    syn;
  logic          op;
  err_class_t    cls;
  logic [CW-1:0] fixed;
  logic          fixable;
  logic          last;
  logic          adv;

  hamming_syndrome u_syn (
    .cw    (mem_rdata),
    .syn   (syn),
    .op    (op),
    .cls   (cls),
    .fixed (fixed)
  );

  assign fixable  = (cls == SINGLE) || (cls == PARITY);
  assign last     = (addr == AW'(DEPTH - 1));
  assign mem_addr = addr;
  assign busy     = state inside {S_ISSUE, S_CHECK, S_WRITE};
  assign done     = (state == S_DONE);
  // CHECK and WRITE are never preempted, keeping the RMW atomic.
  assign host_gnt = host_req &&
                    (state inside {S_IDLE, S_ISSUE, S_DONE});

  // Word finished: clean/uncorrectable in CHECK, or after WRITE.
  assign adv = (state == S_CHECK && !fixable) ||
               (state == S_WRITE);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= S_IDLE;
    else     state <= state_n;
  end

  always_comb begin
    state_n = state;
    mem_re  = 1'b0;
    mem_we  = 1'b0;
    unique case (state)
      S_IDLE: begin
        if (start) state_n = S_ISSUE;
      end
      S_ISSUE: begin
        if (!host_req) begin
          mem_re  = 1'b1;
          state_n = S_CHECK;
        end
      end
      S_CHECK: begin
        if (fixable)   state_n = S_WRITE;
        else if (last) state_n = S_DONE;
        else           state_n = S_ISSUE;
      end
      S_WRITE: begin
        mem_we  = 1'b1;
        state_n = last ? S_DONE : S_ISSUE;
      end
      S_DONE: begin
        state_n = S_IDLE;
      end
      default: state_n = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      addr         <= '0;
      corr_count   <= '0;
      uncorr_count <= '0;
      err_addr     <= '0;
      err_flag     <= 1'b0;
      mem_wdata    <= '0;
    end else begin
      if (state == S_IDLE && start) begin
        addr         <= '0;
        corr_count   <= '0;
        uncorr_count <= '0;
        err_flag     <= 1'b0;
      end
      if (state == S_CHECK) begin
        mem_wdata <= fixed;
        if (fixable && corr_count != 16'hFFFF)
          corr_count <= corr_count + 16'd1;
        if (cls == DOUBLE) begin
          if (uncorr_count != 16'hFFFF)
            uncorr_count <= uncorr_count + 16'd1;
          err_addr <= addr;
          err_flag <= 1'b1;
        end
      end
      if (adv && !last) addr <= addr + AW'(1);
    end
  end

endmodule

// File: tb/tb_hamming_scrubber.sv
// Self-checking bench for hamming_scrubber: table of single-fault
// scans, host stall sequence and mid-write reset sequence.
module tb_hamming_scrubber;

  localparam int DEPTH = 64;
  localparam int AW    = 6;
  localparam int CW    = 22;

  logic          clk = 1'b0;
  logic          rst;
  logic          start;
  logic          busy;
  logic          done;
  logic          host_req;
  logic          host_gnt;
  logic [AW-1:0] mem_addr;
  logic          mem_re;
  logic [CW-1:0] mem_rdata;
  logic          mem_we;
  logic [CW-1:0] mem_wdata;
  logic [15:0]   corr_count;
  logic [15:0]   uncorr_count;
  logic [AW-1:0] err_addr;
  logic          err_flag;

  hamming_scrubber #(.DEPTH(DEPTH), .AW(AW), .CW(CW)) dut (
    .clk          (clk),
    .rst          (rst),
    .start        (start),
    .busy         (busy),
    .done         (done),
    .host_req     (host_req),
    .host_gnt     (host_gnt),
    .mem_addr     (mem_addr),
    .mem_re       (mem_re),
    .mem_rdata    (mem_rdata),
    .mem_we       (mem_we),
    .mem_wdata    (mem_wdata),
    .corr_count   (corr_count),
    .uncorr_count (uncorr_count),
    .err_addr     (err_addr),
    .err_flag     (err_flag)
  );

  always #5 clk = ~clk;

  logic [CW-1:0] mem [DEPTH];
  always @(posedge clk) begin
    if (mem_re) mem_rdata <= mem[mem_addr];
    if (mem_we) mem[mem_addr] <= mem_wdata;
  end

  int pos = 0;
  always @(posedge clk) pos <= pos + 1;

  int n_chk  = 0;
  int n_pass = 0;

  task automatic chk(input string nm, input logic [31:0] act,
                     input logic [31:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h want %0h", nm, act, exp);
  endtask

  typedef struct {
    logic [AW-1:0] a;
    logic [CW-1:0] d;
  } wr_t;
  wr_t exp_q[$];
  bit  mon_on = 1'b1;

  // Scoreboard: every observed write must match the queue head.
  always @(negedge clk) begin
    if (mon_on && !rst) begin
      if (mem_re && mem_we) chk("re_we_overlap", 1, 0);
      if (host_gnt && (mem_re || mem_we))
        chk("gnt_overlap", 1, 0);
      if (mem_we) begin
        if (exp_q.size() == 0) begin
          chk("unexpected_write", {26'd0, mem_addr}, 32'hFFFF);
        end else begin
          wr_t e;
          e = exp_q.pop_front();
          chk("wr_addr", {26'd0, mem_addr}, {26'd0, e.a});
          chk("wr_data", {10'd0, mem_wdata}, {10'd0, e.d});
        end
      end
    end
  end

  typedef struct {
    string         nm;
    logic [AW-1:0] a;
    logic [CW-1:0] w;
    bit            wr;
    logic [15:0]   corr;
    logic [15:0]   uncorr;
    logic [AW-1:0] eaddr;
    logic          eflag;
    int            dcyc;
  } vec_t;
  vec_t vt [6];

  task automatic clear_mem();
    for (int i = 0; i < DEPTH; i++) mem[i] = '0;
  endtask

  task automatic do_start();
    @(negedge clk);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
  endtask

  // Returns cycle of done, counting the start cycle as 0.
  task automatic wait_done(input int t0, output int cyc);
    cyc = -1;
    while (pos - t0 < 2000) begin
      if (done) begin
        cyc = pos - t0;
        break;
      end
      @(negedge clk);
    end
    if (cyc < 0) chk("done_timeout", 0, 1);
  endtask

  int t0;
  int dc;

  initial begin
    vt[0] = '{"clean",  6'd0,  22'h000000, 0, 16'd0, 16'd0,
              6'd0,  1'b0, 129};
    vt[1] = '{"pos7",   6'd5,  22'h000080, 1, 16'd1, 16'd0,
              6'd0,  1'b0, 130};
    vt[2] = '{"double", 6'd9,  22'h000048, 0, 16'd0, 16'd1,
              6'd9,  1'b1, 129};
    vt[3] = '{"parity", 6'd2,  22'h000001, 1, 16'd1, 16'd0,
              6'd0,  1'b0, 130};
    vt[4] = '{"pos21",  6'd63, 22'h200000, 1, 16'd1, 16'd0,
              6'd0,  1'b0, 130};
    vt[5] = '{"syn31",  6'd0,  22'h200104, 0, 16'd0, 16'd1,
              6'd0,  1'b1, 129};

    rst = 1'b1; start = 1'b0; host_req = 1'b0;
    clear_mem();
    repeat (2) @(negedge clk);
    chk("rst_busy", busy, 0);
    chk("rst_done", done, 0);
    chk("rst_re", mem_re, 0);
    chk("rst_we", mem_we, 0);
    chk("rst_wdata", mem_wdata, 0);
    chk("rst_corr", corr_count, 0);
    chk("rst_uncorr", uncorr_count, 0);
    chk("rst_eflag", err_flag, 0);
    chk("rst_addr", mem_addr, 0);
    host_req = 1'b1;
    #1 chk("rst_gnt", host_gnt, 1);
    host_req = 1'b0;
    #1 chk("rst_gnt0", host_gnt, 0);
    @(negedge clk);
    rst = 1'b0;

    foreach (vt[k]) begin
      clear_mem();
      mem[vt[k].a] = vt[k].w;
      if (vt[k].wr) exp_q.push_back('{vt[k].a, '0});
      @(negedge clk);
      start = 1'b1;
      t0 = pos;
      @(negedge clk);
      start = 1'b0;
      chk({vt[k].nm, "_re1"}, mem_re, 1);
      chk({vt[k].nm, "_ra1"}, mem_addr, 0);
      wait_done(t0, dc);
      chk({vt[k].nm, "_dcyc"}, dc, vt[k].dcyc);
      chk({vt[k].nm, "_corr"}, corr_count, vt[k].corr);
      chk({vt[k].nm, "_uncorr"}, uncorr_count, vt[k].uncorr);
      chk({vt[k].nm, "_eflag"}, err_flag, vt[k].eflag);
      if (vt[k].eflag)
        chk({vt[k].nm, "_eaddr"}, err_addr, vt[k].eaddr);
      chk({vt[k].nm, "_q"}, exp_q.size(), 0);
      exp_q.delete();
      @(negedge clk);
      chk({vt[k].nm, "_idle"}, {busy, done}, 2'b00);
    end

    // Host stalls the scan for 10 cycles in ISSUE at addr 4;
    // a start pulse while busy must be ignored.
    clear_mem();
    @(negedge clk);
    start = 1'b1;
    t0 = pos;
    @(negedge clk);
    start = 1'b0;
    begin
      int n = 0;
      while (!(mem_re && mem_addr == 6'd4) && n < 100) begin
        @(negedge clk);
        n++;
      end
      chk("host_reach4", n < 100, 1);
    end
    start = 1'b1;
    for (int i = 0; i < 10; i++) begin
      host_req = 1'b1;
      #1;
      chk("host_gnt", host_gnt, 1);
      chk("host_re0", mem_re, 0);
      @(negedge clk);
      start = 1'b0;
    end
    host_req = 1'b0;
    #1;
    chk("host_resume_re", mem_re, 1);
    chk("host_resume_a", mem_addr, 4);
    wait_done(t0, dc);
    chk("host_dcyc", dc, 139);
    @(negedge clk);

    // Reset during WRITE aborts; the restart re-reads from addr 0.
    clear_mem();
    mem[3] = 22'h000080;
    exp_q.push_back('{6'd3, '0});
    do_start();
    begin
      int n = 0;
      while (!mem_we && n < 100) begin
        @(negedge clk);
        n++;
      end
      chk("rw_reach_we", n < 100, 1);
    end
    #2;
    rst = 1'b1;
    #1;
    chk("rw_we0", mem_we, 0);
    chk("rw_busy0", busy, 0);
    chk("rw_wdata0", mem_wdata, 0);
    chk("rw_corr0", corr_count, 0);
    chk("rw_addr0", mem_addr, 0);
    @(negedge clk);
    chk("rw_mem_kept", mem[3], 22'h000080);
    rst = 1'b0;
    exp_q.delete();
    exp_q.push_back('{6'd3, '0});
    @(negedge clk);
    start = 1'b1;
    t0 = pos;
    @(negedge clk);
    start = 1'b0;
    chk("rw_re1", mem_re, 1);
    chk("rw_ra1", mem_addr, 0);
    wait_done(t0, dc);
    chk("rw_dcyc", dc, 130);
    chk("rw_corr", corr_count, 1);
    chk("rw_q", exp_q.size(), 0);
    chk("rw_mem_fixed", mem[3], 22'h000000);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule

// File: doc/hamming_scrubber.md
# hamming_scrubber

Background ECC scrubber for a memory of 22-bit SECDED codewords (16 data, 5 Hamming check, 1 overall parity). On a start pulse it walks every address once. For each word it reads the codeword, checks it with the Hamming syndrome logic, writes back the corrected word on correctable errors, and counts and logs uncorrectable ones. It shares the single memory port with a host requester and always yields to the host between words.

## Interface
- `DEPTH`, default 64: number of memory words scanned, addresses 0..DEPTH-1.
- `AW`, default 6: address width, where `2**AW >= DEPTH`.
- `CW`, default 22: codeword width. Fixed at 22; other values are unsupported.
- `clk` in 1: single clock, rising edge.
- `rst` in 1: asynchronous, active-high reset.
- `start` in 1: one-cycle pulse that begins a scan. Ignored unless the FSM is in IDLE.
- `busy` out 1: high while a scan is in progress (ISSUE, CHECK, WRITE states).
- `done` out 1: one-cycle pulse when a scan completes.
- `host_req` in 1: host wants the memory port.
- `host_gnt` out 1: host owns the port this cycle.
- `mem_addr` out AW: scrubber address.
- `mem_re` out 1: read strobe. `mem_rdata` is valid in the following cycle.
- `mem_rdata` in CW: read data.
- `mem_we` out 1: write strobe.
- `mem_wdata` out CW: corrected codeword.
- `corr_count` out 16: corrected words in the last or current scan. Saturates at 16'hFFFF.
- `uncorr_count` out 16: uncorrectable words. Saturates at 16'hFFFF.
- `err_addr` out AW: address of the most recent uncorrectable word.
- `err_flag` out 1: sticky; set on any uncorrectable word. Cleared only by `rst` or an accepted `start`.

## Operation
- Codeword layout:
  - `cw[21:1]` holds Hamming positions 21..1; check bits sit at positions 1, 2, 4, 8, 16.
  - `cw[0]` is the overall parity, even across all 22 bits.
- Syndrome `s[4:0]`: `s[i]` = XOR of `cw[p]` for p in 1..21 where bit i of p is set.
- Overall parity `op` = XOR of `cw[21:0]`.
- Classification:
  - s==0, op==0: CLEAN.
  - s!=0, op==1, s<=21: SINGLE. Flip `cw[s]`.
  - s==0, op==1: PARITY. Flip `cw[0]`.
  - s!=0, op==0: DOUBLE.
  - s>21 (any op): DOUBLE.
- SINGLE and PARITY are correctable: write back and increment `corr_count`.
- DOUBLE: no write; increment `uncorr_count`, load `err_addr`, set `err_flag`.
- FSM states:
  - IDLE: `start` clears both counters and `err_flag`, sets addr=0, and moves to ISSUE.
  - ISSUE: if `host_req` is high, stay in ISSUE with `mem_re`=0. Otherwise `mem_re`=1 and go to CHECK.
  - CHECK: classify `mem_rdata`. Correctable goes to WRITE. Otherwise advance.
  - WRITE: `mem_we`=1 with the corrected word at the same address, then advance.
  - Advance: if addr==DEPTH-1, go to DONE; else addr+1 and go to ISSUE.
  - DONE: `done`=1 for one cycle, then IDLE.
- Port arbitration: `host_gnt` = `host_req` AND state in {IDLE, ISSUE, DONE}.
  - CHECK and WRITE are never preempted, so read-modify-write is atomic.
  - The host waits at most 2 cycles.
- `mem_re` and `mem_we` are never high in the same cycle, and never high when `host_gnt`=1.
- `start` while busy is ignored. `start` coincident with `host_req` in IDLE is accepted; the scan then stalls in ISSUE.

## Timing
- Reset values: FSM in IDLE; addr, both counters, `err_addr`, `err_flag`, `busy`, `done`, `mem_re`, `mem_we`, `mem_wdata` all 0. `host_gnt` follows `host_req`.
- Clean word costs 2 cycles (ISSUE, CHECK). Corrected word costs 3 cycles (ISSUE, CHECK, WRITE).
- With `start` at cycle 0 and no host traffic:
  - first `mem_re` at cycle 1;
  - `done` at cycle 2·DEPTH+1 plus 1 per corrected word.
- Counters and `err_addr` update on the clock edge that leaves CHECK.
- `mem_wdata` is registered from the corrected word in CHECK and held through WRITE.
- `host_gnt`, `mem_re` and `mem_we` are combinational decodes of state and `host_req`.
- Reset mid-scan aborts immediately. No write is issued after `rst` asserts, and a new `start` restarts from addr 0.

## Structure
- Shared package `hamming_pkg`:
  - `CW`=22;
  - error-class enum {CLEAN, SINGLE, PARITY, DOUBLE};
  - FSM state enum.
- Sub-module `hamming_syndrome`: combinational; codeword in → syndrome, op, class, corrected codeword out. Reused by other ECC blocks.
- Top holds the FSM, address counter, saturating counters and arbitration.

## Test plan
- Memory of all 22'h0, DEPTH=64, `start` at cycle 0 → `done` at cycle 129; counts 0; `mem_we` never high.
- addr 5 = 22'h000080 (position 7 flipped) → one write of 22'h0 to addr 5; `corr_count`=1; `done` at cycle 130.
- addr 9 = 22'h000048 (positions 3 and 6 flipped) → no write; `uncorr_count`=1, `err_addr`=9, `err_flag`=1.
- addr 2 = 22'h000001 (parity bit only) → write of 22'h0 to addr 2; `corr_count`=1.
- `host_req` held 10 cycles starting in ISSUE at addr 4 → `host_gnt`=1 and `mem_re`=0 for those 10 cycles; the scan resumes at addr 4; `done` slips by 10 cycles.
- `rst` pulsed while in WRITE → `mem_we` drops immediately; all outputs 0; the next `start` re-reads from addr 0.
